// File: rtl/uart_cmd_ctrl.sv
// Host command sequencer in front of the UART core: synchronizes the host bus,
// assembles TX bytes and the prescaler from nibble pairs, and holds config/status.
module uart_cmd_ctrl #(
    parameter logic [7:0] PREDIV_RESET = 8'd1,
    parameter int         SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] io_in7,
    input  logic       io_strobe,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] io_prediv,
    output logic       io_resetCommandStrobe,
    output logic       io_gatedTxdStopBitSupport,
    output logic       io_loopback,
    output logic [1:0] status
);

    // state    | meaning
    // IDLE     | no nibble held
    // DATA_LO  | TX data low nibble held
    // PDIV_LO  | prescaler low nibble held
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_DATA_LO = 2'd1;
    localparam logic [1:0] ST_PDIV_LO = 2'd2;

    localparam logic [1:0] CMD_DATA   = 2'd0;
    localparam logic [1:0] CMD_CONFIG = 2'd1;
    localparam logic [1:0] CMD_PREDIV = 2'd2;

    logic [SYNC_STAGES-1:0]      strobe_sync_q, strobe_sync_d;
    logic [SYNC_STAGES-1:0][6:0] in7_sync_q, in7_sync_d;
    logic                        strobe_prev_q, strobe_prev_d;

    logic [1:0] state_q, state_d;
    logic [3:0] nib_q, nib_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_valid_q, tx_valid_d;
    logic [7:0] prediv_q, prediv_d;
    logic       rst_strb_q, rst_strb_d;
    logic       gated_q, gated_d;
    logic       loop_q, loop_d;
    logic [1:0] status_q, status_d;

    logic       cmd_fire;
    logic [1:0] cmd_op;
    logic [4:0] cmd_p;
    logic       from_idle;

    assign cmd_fire = strobe_sync_q[SYNC_STAGES-1] & ~strobe_prev_q;
    assign cmd_op   = in7_sync_q[SYNC_STAGES-1][1:0];
    assign cmd_p    = in7_sync_q[SYNC_STAGES-1][6:2];

    always_comb begin
        strobe_sync_d = {strobe_sync_q[SYNC_STAGES-2:0], io_strobe};
        in7_sync_d    = {in7_sync_q[SYNC_STAGES-2:0], io_in7};
        strobe_prev_d = strobe_sync_q[SYNC_STAGES-1];
    end

    always_comb begin
        state_d    = state_q;
        nib_d      = nib_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        prediv_d   = prediv_q;
        rst_strb_d = 1'b0;
        gated_d    = gated_q;
        loop_d     = loop_q;
        status_d   = status_q;
        from_idle  = 1'b0;

        if (tx_valid_q && tx_ready) begin
            tx_valid_d = 1'b0;
        end

        if (cmd_fire) begin
            from_idle = 1'b1;
            case (state_q)
                ST_DATA_LO: begin
                    if (cmd_op == CMD_DATA) begin
                        from_idle = 1'b0;
                        if (!cmd_p[4]) begin
                            nib_d = cmd_p[3:0];
                        end else begin
                            state_d = ST_IDLE;
                            // a byte may load in the same cycle the core takes the previous one
                            if (!tx_valid_q || tx_ready) begin
                                tx_data_d  = {cmd_p[3:0], nib_q};
                                tx_valid_d = 1'b1;
                            end else begin
                                status_d[0] = 1'b1;
                            end
                        end
                    end else begin
                        status_d[1] = 1'b1;
                    end
                end
                ST_PDIV_LO: begin
                    if (cmd_op == CMD_PREDIV) begin
                        from_idle = 1'b0;
                        if (!cmd_p[4]) begin
                            nib_d = cmd_p[3:0];
                        end else begin
                            state_d  = ST_IDLE;
                            prediv_d = {cmd_p[3:0], nib_q};
                        end
                    end else begin
                        status_d[1] = 1'b1;
                    end
                end
                default: ;
            endcase

            // out-of-sequence commands are replayed as if from IDLE
            if (from_idle) begin
                state_d = ST_IDLE;
                case (cmd_op)
                    CMD_DATA, CMD_PREDIV: begin
                        if (cmd_p[4]) begin
                            status_d[1] = 1'b1;
                        end else begin
                            nib_d   = cmd_p[3:0];
                            state_d = (cmd_op == CMD_DATA) ? ST_DATA_LO : ST_PDIV_LO;
                        end
                    end
                    CMD_CONFIG: begin
                        if (cmd_p == 5'b11000) begin
                            rst_strb_d = 1'b1;
                            tx_valid_d = 1'b0;
                            prediv_d   = PREDIV_RESET;
                            gated_d    = 1'b0;
                            loop_d     = 1'b0;
                            status_d   = 2'b00;
                        end else if (cmd_p == 5'b11001) begin
                            status_d = 2'b00;
                        end else if (cmd_p[4:3] == 2'b10) begin
                            gated_d = cmd_p[0];
                            loop_d  = cmd_p[1];
                        end
                    end
                    default: begin
                        status_d[1] = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            strobe_sync_q <= '0;
            in7_sync_q    <= '0;
            strobe_prev_q <= 1'b0;
            state_q       <= ST_IDLE;
            nib_q         <= 4'h0;
            tx_data_q     <= 8'h00;
            tx_valid_q    <= 1'b0;
            prediv_q      <= PREDIV_RESET;
            rst_strb_q    <= 1'b0;
            gated_q       <= 1'b0;
            loop_q        <= 1'b0;
            status_q      <= 2'b00;
        end else begin
            strobe_sync_q <= strobe_sync_d;
            in7_sync_q    <= in7_sync_d;
            strobe_prev_q <= strobe_prev_d;
            state_q       <= state_d;
            nib_q         <= nib_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            prediv_q      <= prediv_d;
            rst_strb_q    <= rst_strb_d;
            gated_q       <= gated_d;
            loop_q        <= loop_d;
            status_q      <= status_d;
        end
    end

    assign tx_data                   = tx_data_q;
    assign tx_valid                  = tx_valid_q;
    assign io_prediv                 = prediv_q;
    assign io_resetCommandStrobe     = rst_strb_q;
    assign io_gatedTxdStopBitSupport = gated_q;
    assign io_loopback               = loop_q;
    assign status                    = status_q;

endmodule
